// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the Mealy sequence detectors: WIDTH-bit words in
// over valid/ready, one bit per clock out on w, with a one-word holding register.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             w,
  output logic             w_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [CW-1:0]    cnt;
  logic             accept_c;
  logic             last_c;
  logic             load_c;
  logic             shift_c;
  logic [WIDTH-1:0] load_word_c;

  // Bit that leaves first from a word, and what remains after it has been sent.
  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  function automatic logic [WIDTH-1:0] rest_bits(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? {word[WIDTH-2:0], 1'b0} : {1'b0, word[WIDTH-1:1]};
  endfunction

  assign accept_c = load_valid & load_ready;
  assign last_c   = (cnt == LAST);

  // Next-state decode: new frame load, in-frame shift, or hold capture.
  always_comb begin
    state_n     = state;
    hold_n      = hold;
    hold_full_n = hold_full;
    load_c      = 1'b0;
    shift_c     = 1'b0;
    load_word_c = data_in;
    case (state)
      IDLE: begin
        if (accept_c) begin
          load_c  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (last_c) begin
          if (hold_full) begin
            load_c      = 1'b1;
            load_word_c = hold;
            hold_full_n = 1'b0;
          end else if (accept_c) begin
            // Word arriving on the last-bit edge skips the holding register.
            load_c = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          shift_c = 1'b1;
          if (accept_c) begin
            hold_n      = data_in;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      shreg       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      cnt         <= '0;
      w           <= IDLE_BIT;
      w_valid     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      state       <= state_n;
      hold        <= hold_n;
      hold_full   <= hold_full_n;
      load_ready  <= !hold_full_n;
      busy        <= (state_n == SHIFT) | hold_full_n;
      frame_start <= load_c;
      if (load_c) begin
        shreg   <= rest_bits(load_word_c);
        w       <= first_bit(load_word_c);
        w_valid <= 1'b1;
        cnt     <= '0;
      end else if (shift_c) begin
        shreg   <= rest_bits(shreg);
        w       <= first_bit(shreg);
        w_valid <= 1'b1;
        cnt     <= cnt + CW'(1);
      end else begin
        w       <= IDLE_BIT;
        w_valid <= 1'b0;
        cnt     <= '0;
      end
    end
  end

endmodule
